// File: rtl/cronometro_ctrl.sv
// -----------------------------------------------------------------------------
// cronometro_ctrl
// Stopwatch sequencing controller. It synchronizes three debounced push-button
// levels and turns each press into a single action. It divides CLK down to a
// 1/100 s tick and keeps the elapsed time in the encoding the 7-segment decoder
// expects.
//
// Parameters
//   TICK_DIV   CLK cycles per 1/100 s tick (>= 2)
// Ports
//   CLK        system clock, rising edge
//   RSTN       asynchronous active-low reset
//   START_STOP start/stop button level, active-high
//   ZERA       clear button level, active-high
//   VOLTA      lap button level, active-high
//   SEG        seconds*100 + hundredths (0..5999), registered
//   MINU       minutes (0..59), registered
//   H          hours (0..23), registered
//   RUN        high in RUN and LAP
//   HOLD       high in LAP (display frozen)
//
// Build option: define LAP_ROUTE_EN to enable the LAP state. Without it, VOLTA
// is ignored, HOLD is tied low and the outputs always follow the live counts.
//
// state | meaning
// IDLE  | counts zero, waiting for start
// RUN   | counting, outputs live
// PAUSE | counting halted, prescaler phase held
// LAP   | counting, outputs frozen at lap value
// -----------------------------------------------------------------------------
module cronometro_ctrl #(
    parameter int TICK_DIV = 500000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START_STOP,
    input  logic        ZERA,
    input  logic        VOLTA,
    output logic [12:0] SEG,
    output logic [6:0]  MINU,
    output logic [5:0]  H,
    output logic        RUN,
    output logic        HOLD
);

    localparam int PC_W = $clog2(TICK_DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

`ifdef LAP_ROUTE_EN
    localparam int BTN_N = 3;
`else
    localparam int BTN_N = 2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP} state_t;

    state_t           state_q, state_d;
    logic [BTN_N-1:0] btn_in, s1_q, s2_q, prev_q, btn_edge;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [12:0]      cs_q, cs_d, seg_q, seg_d;
    logic [6:0]       mm_q, mm_d, minu_q, minu_d;
    logic [5:0]       hh_q, hh_d, h_q, h_d;
    logic             run_q, run_d, hold_q, hold_d;
    logic             running, tick, clear;

`ifdef LAP_ROUTE_EN
    assign btn_in = {VOLTA, ZERA, START_STOP};
`else
    logic unused_volta;
    assign unused_volta = VOLTA;
    assign btn_in = {ZERA, START_STOP};
`endif

    // A button held through reset is seen as already high, so it acts only
    // after it has been released and pressed again.
    assign btn_edge = s2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE:  if (btn_edge[0]) state_d = ST_RUN;
            ST_RUN: begin
                if (btn_edge[0]) state_d = ST_PAUSE;
`ifdef LAP_ROUTE_EN
                else if (btn_edge[2]) state_d = ST_LAP;
`endif
            end
            ST_PAUSE: begin
                if (btn_edge[0]) state_d = ST_RUN;
                else if (btn_edge[1]) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end
            end
`ifdef LAP_ROUTE_EN
            ST_LAP: begin
                if (btn_edge[0]) state_d = ST_PAUSE;
                else if (btn_edge[2]) state_d = ST_RUN;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // The prescaler is held, not cleared, in PAUSE so that resuming keeps the
    // sub-tick phase.
    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick    = running && (pc_q == PC_LAST);

    always_comb begin
        pc_d = pc_q;
        cs_d = cs_q;
        mm_d = mm_q;
        hh_d = hh_q;
        if (clear) begin
            pc_d = '0;
            cs_d = '0;
            mm_d = '0;
            hh_d = '0;
        end else if (running) begin
            pc_d = tick ? '0 : pc_q + 1'b1;
            if (tick) begin
                if (cs_q == 13'd5999) begin
                    cs_d = '0;
                    if (mm_q == 7'd59) begin
                        mm_d = '0;
                        hh_d = (hh_q == 6'd23) ? '0 : hh_q + 1'b1;
                    end else begin
                        mm_d = mm_q + 1'b1;
                    end
                end else begin
                    cs_d = cs_q + 1'b1;
                end
            end
        end
    end

    // The output registers double as the lap snapshot. When LAP is entered
    // they load the pre-tick counts, so a tick on that edge only reaches the
    // live counters.
    always_comb begin
        seg_d  = cs_d;
        minu_d = mm_d;
        h_d    = hh_d;
        run_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
        hold_d = 1'b0;
`ifdef LAP_ROUTE_EN
        if (state_d == ST_LAP) begin
            hold_d = 1'b1;
            if (state_q != ST_LAP) begin
                seg_d  = cs_q;
                minu_d = mm_q;
                h_d    = hh_q;
            end else begin
                seg_d  = seg_q;
                minu_d = minu_q;
                h_d    = h_q;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            s1_q    <= '1;
            s2_q    <= '1;
            prev_q  <= '1;
            pc_q    <= '0;
            cs_q    <= '0;
            mm_q    <= '0;
            hh_q    <= '0;
            seg_q   <= '0;
            minu_q  <= '0;
            h_q     <= '0;
            run_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            pc_q    <= pc_d;
            cs_q    <= cs_d;
            mm_q    <= mm_d;
            hh_q    <= hh_d;
            seg_q   <= seg_d;
            minu_q  <= minu_d;
            h_q     <= h_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
        end
    end

    assign SEG  = seg_q;
    assign MINU = minu_q;
    assign H    = h_q;
    assign RUN  = run_q;
    assign HOLD = hold_q;

endmodule
